// File: rtl/insn_queue.sv
// Instruction queue between the fetch frontend and instruction decode.
// Circular buffer of D entries, FW push lanes in and IW head lanes out.
// Head outputs come from registered state only, so a pushed entry becomes
// visible one cycle later and id_pop_cnt never feeds the id_* outputs.

`ifndef NCPU_INSN_DW
`define NCPU_INSN_DW 32
`endif
`ifndef PC_W
`define PC_W 32
`endif
`ifndef FNT_EXC_W
`define FNT_EXC_W 4
`endif
`ifndef BPU_UPD_W
`define BPU_UPD_W 8
`endif

module insn_queue #(
    parameter int CONFIG_P_ISSUE_WIDTH = 1,
    parameter int CONFIG_P_FETCH_WIDTH = 1,
    parameter int CONFIG_P_IQ_DEPTH    = 3,
    localparam int IW       = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int FW       = 1 << CONFIG_P_FETCH_WIDTH,
    localparam int INS_W    = `NCPU_INSN_DW,
    localparam int PC_WD    = `PC_W,
    localparam int EXC_W    = `FNT_EXC_W,
    localparam int BPU_W    = `BPU_UPD_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [FW-1:0]                   iq_push_valid,
    input  logic [FW*INS_W-1:0]             iq_ins,
    input  logic [FW*PC_WD-1:0]             iq_pc,
    input  logic [FW*EXC_W-1:0]             iq_exc,
    input  logic [FW*BPU_W-1:0]             iq_bpu_upd,
    output logic                            iq_ready,
    output logic [IW-1:0]                   id_valid,
    output logic [IW*INS_W-1:0]             id_ins,
    output logic [IW*PC_WD-1:0]             id_pc,
    output logic [IW*EXC_W-1:0]             id_exc,
    output logic [IW*BPU_W-1:0]             id_bpu_upd,
    input  logic [CONFIG_P_ISSUE_WIDTH:0]   id_pop_cnt
);

    localparam int PW = CONFIG_P_IQ_DEPTH;
    localparam int CW = PW + 1;
    localparam int D  = 1 << PW;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_WD-1:0] pc;
        logic [EXC_W-1:0] exc;
        logic [BPU_W-1:0] bpu_upd;
    } entry_t;

    entry_t          mem [D];
    entry_t          push_lane [FW];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic [CW-1:0]   push_n;
    logic [CW-1:0]   push_amt;
    logic [CW-1:0]   pop_req;
    logic [CW-1:0]   pop_n;
    logic            push_en;

    // Free-slot check and push/pop amounts, all from pre-update occupancy.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        free     = CW'(D) - count;
        iq_ready = (free >= CW'(FW));
        push_en  = iq_ready && !flush;
        push_n   = '0;
        for (int k = 0; k < FW; k++) begin
            push_n = push_n + CW'(iq_push_valid[k]);
        end
        push_amt = push_en ? push_n : '0;
        pop_req  = CW'(id_pop_cnt);
        pop_n    = (pop_req < count) ? pop_req : count;
    end

    // Unpack the push lanes into entry records.
    always_comb begin
        for (int k = 0; k < FW; k++) begin
            push_lane[k].ins     = iq_ins[k*INS_W +: INS_W];
            push_lane[k].pc      = iq_pc[k*PC_WD +: PC_WD];
            push_lane[k].exc     = iq_exc[k*EXC_W +: EXC_W];
            push_lane[k].bpu_upd = iq_bpu_upd[k*BPU_W +: BPU_W];
        end
    end

    // Pointer and occupancy register; reset beats flush, flush beats traffic.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PW'(pop_n);
            wptr  <= wptr + PW'(push_amt);
            count <= count + push_amt - pop_n;
        end
    end

    // Payload write of lanes 0..push_n-1 at consecutive slots from wptr.
    // NOTE: payload storage has no reset; id_valid qualifies every output lane.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            for (int k = 0; k < FW; k++) begin
                if (CW'(k) < push_n) begin
                    mem[wptr + PW'(k)] <= push_lane[k];
                end
            end
        end
    end

    // Head lanes read straight from storage at rptr+i (pointer arithmetic wraps mod D).
    for (genvar i = 0; i < IW; i++) begin : g_head
        entry_t head;
        assign head                          = mem[rptr + PW'(i)];
        assign id_valid[i]                   = (count > CW'(i));
        assign id_ins[i*INS_W +: INS_W]      = head.ins;
        assign id_pc[i*PC_WD +: PC_WD]       = head.pc;
        assign id_exc[i*EXC_W +: EXC_W]      = head.exc;
        assign id_bpu_upd[i*BPU_W +: BPU_W]  = head.bpu_upd;
    end

endmodule

// File: tb/tb_insn_queue.sv
// Directed bench for insn_queue at default sizing (IW=2, FW=2, D=8).
// Expected values are hand-derived per step and compared through check().

`ifndef NCPU_INSN_DW
`define NCPU_INSN_DW 32
`endif
`ifndef PC_W
`define PC_W 32
`endif
`ifndef FNT_EXC_W
`define FNT_EXC_W 4
`endif
`ifndef BPU_UPD_W
`define BPU_UPD_W 8
`endif

module tb_insn_queue;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [1:0]    iq_push_valid;
    logic [63:0]   iq_ins;
    logic [63:0]   iq_pc;
    logic [7:0]    iq_exc;
    logic [15:0]   iq_bpu_upd;
    logic          iq_ready;
    logic [1:0]    id_valid;
    logic [63:0]   id_ins;
    logic [63:0]   id_pc;
    logic [7:0]    id_exc;
    logic [15:0]   id_bpu_upd;
    logic [1:0]    id_pop_cnt;

    int total = 0;
    int bad   = 0;

    insn_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .iq_push_valid (iq_push_valid),
        .iq_ins        (iq_ins),
        .iq_pc         (iq_pc),
        .iq_exc        (iq_exc),
        .iq_bpu_upd    (iq_bpu_upd),
        .iq_ready      (iq_ready),
        .id_valid      (id_valid),
        .id_ins        (id_ins),
        .id_pc         (id_pc),
        .id_exc        (id_exc),
        .id_bpu_upd    (id_bpu_upd),
        .id_pop_cnt    (id_pop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare head lanes; payload only where the lane is expected valid.
    task automatic chk_head(input string tag, input logic [1:0] v,
                            input logic [31:0] p0, input logic [31:0] p1);
        check({tag, ".valid"}, 64'(id_valid), 64'(v));
        if (v[0]) begin
            check({tag, ".pc0"},  64'(id_pc[31:0]),  64'(p0));
            check({tag, ".ins0"}, 64'(id_ins[31:0]), 64'(insn_of(p0)));
        end
        if (v[1]) begin
            check({tag, ".pc1"},  64'(id_pc[63:32]),  64'(p1));
            check({tag, ".ins1"}, 64'(id_ins[63:32]), 64'(insn_of(p1)));
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic rdy);
        check({tag, ".count"}, 64'(dut.count), 64'(cnt));
        check({tag, ".ready"}, 64'(iq_ready),  64'(rdy));
    endtask

    task automatic drive(input logic [1:0] pv, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] pop, input logic fl, input logic rs);
        iq_push_valid = pv;
        iq_pc         = {p1, p0};
        iq_ins        = {insn_of(p1), insn_of(p0)};
        iq_exc        = {p1[5:2], p0[5:2]};
        iq_bpu_upd    = {p1[9:2], p0[9:2]};
        id_pop_cnt    = pop;
        flush         = fl;
        rst           = rs;
    endtask

    // One clock with the given inputs, then sample #1 after the edge.
    task automatic cyc(input logic [1:0] pv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl, input logic rs);
        drive(pv, p0, p1, pop, fl, rs);
        @(posedge clk);
        #1;
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);

        // Reset state
        cyc(2'b00, 0, 0, 0, 0, 1);
        chk_state("rst", 0, 1'b1);
        check("rst.valid", 64'(id_valid), 64'd0);
        check("rst.rptr", 64'(dut.rptr), 64'd0);

        // First push: no bypass before the edge, visible one cycle later
        drive(2'b11, 32'h100, 32'h104, 2'd0, 1'b0, 1'b0);
        #1;
        check("nobypass.valid", 64'(id_valid), 64'd0);
        @(posedge clk);
        #1;
        drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        chk_head("push1", 2'b11, 32'h100, 32'h104);
        chk_state("push1", 2, 1'b1);

        // Fill to full, then a dropped push
        cyc(2'b11, 32'h108, 32'h10c, 0, 0, 0);
        cyc(2'b11, 32'h110, 32'h114, 0, 0, 0);
        cyc(2'b11, 32'h118, 32'h11c, 0, 0, 0);
        chk_state("full", 8, 1'b0);
        chk_head("full", 2'b11, 32'h100, 32'h104);
        cyc(2'b11, 32'h200, 32'h204, 0, 0, 0);
        chk_state("drop", 8, 1'b0);
        check("drop.wptr", 64'(dut.wptr), 64'd0);

        // Drain two per cycle; the dropped 0x200 must never appear
        for (int j = 0; j < 4; j++) begin
            chk_head($sformatf("drain%0d", j), 2'b11, 32'h100 + 32'(8*j), 32'h104 + 32'(8*j));
            cyc(2'b00, 0, 0, 2, 0, 0);
        end
        chk_state("empty", 0, 1'b1);
        check("empty.valid", 64'(id_valid), 64'd0);

        // Move pointers to 6
        cyc(2'b11, 32'h500, 32'h504, 0, 0, 0);
        cyc(2'b11, 32'h508, 32'h50c, 0, 0, 0);
        cyc(2'b11, 32'h510, 32'h514, 0, 0, 0);
        cyc(2'b00, 0, 0, 2, 0, 0);
        cyc(2'b00, 0, 0, 2, 0, 0);
        cyc(2'b00, 0, 0, 2, 0, 0);
        check("mv.rptr", 64'(dut.rptr), 64'd6);
        chk_state("mv", 0, 1'b1);

        // count=7, rptr=6: entries 6,7,0,1,2,3,4
        cyc(2'b11, 32'h600, 32'h604, 0, 0, 0);
        cyc(2'b11, 32'h608, 32'h60c, 0, 0, 0);
        cyc(2'b11, 32'h610, 32'h614, 0, 0, 0);
        cyc(2'b01, 32'h618, 32'h0,   0, 0, 0);
        chk_state("c7", 7, 1'b0);
        chk_head("c7", 2'b11, 32'h600, 32'h604);

        // Pop 2 with push 2 while not ready: pop applies, push dropped
        cyc(2'b11, 32'h300, 32'h304, 2, 0, 0);
        chk_state("popdrop", 5, 1'b1);
        check("popdrop.rptr", 64'(dut.rptr), 64'd0);
        chk_head("popdrop", 2'b11, 32'h608, 32'h60c);
        cyc(2'b00, 0, 0, 2, 0, 0);
        chk_head("popdrop2", 2'b11, 32'h610, 32'h614);
        cyc(2'b00, 0, 0, 2, 0, 0);
        chk_head("popdrop3", 2'b01, 32'h618, 32'h0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        chk_state("drained", 0, 1'b1);
        check("drained.wptr", 64'(dut.wptr), 64'd5);

        // Write wrap: wptr=7, push 2 lands in entries 7 and 0
        cyc(2'b01, 32'h400, 32'h0, 0, 0, 0);
        cyc(2'b01, 32'h404, 32'h0, 0, 0, 0);
        check("wrap.wptr7", 64'(dut.wptr), 64'd7);
        cyc(2'b11, 32'h408, 32'h40c, 0, 0, 0);
        check("wrap.wptr1", 64'(dut.wptr), 64'd1);
        chk_head("wrap.head", 2'b11, 32'h400, 32'h404);
        cyc(2'b00, 0, 0, 2, 0, 0);
        check("wrap.rptr7", 64'(dut.rptr), 64'd7);
        chk_head("wrap.read", 2'b11, 32'h408, 32'h40c);

        // Over-pop: count=1, pop 2 leaves 0 without underflow
        cyc(2'b00, 0, 0, 1, 0, 0);
        chk_head("c1", 2'b01, 32'h40c, 32'h0);
        cyc(2'b00, 0, 0, 2, 0, 0);
        chk_state("under", 0, 1'b1);
        check("under.valid", 64'(id_valid), 64'd0);
        check("under.rptr", 64'(dut.rptr), 64'd1);

        // Flush with simultaneous push and pop
        cyc(2'b11, 32'h700, 32'h704, 0, 0, 0);
        cyc(2'b11, 32'h708, 32'h70c, 0, 0, 0);
        cyc(2'b01, 32'h710, 32'h0,   0, 0, 0);
        chk_state("c5", 5, 1'b1);
        cyc(2'b11, 32'h720, 32'h724, 1, 1, 0);
        chk_state("flush", 0, 1'b1);
        check("flush.valid", 64'(id_valid), 64'd0);
        check("flush.rptr", 64'(dut.rptr), 64'd0);
        check("flush.wptr", 64'(dut.wptr), 64'd0);

        // Reset mid-traffic with push and pop
        cyc(2'b11, 32'h800, 32'h804, 0, 0, 0);
        cyc(2'b01, 32'h808, 32'h0,   0, 0, 0);
        chk_state("c3", 3, 1'b1);
        cyc(2'b11, 32'h820, 32'h824, 1, 0, 1);
        chk_state("mrst", 0, 1'b1);
        check("mrst.valid", 64'(id_valid), 64'd0);
        check("mrst.wptr", 64'(dut.wptr), 64'd0);

        // Traffic resumes from entry 0
        cyc(2'b11, 32'h900, 32'h904, 0, 0, 0);
        chk_head("resume", 2'b11, 32'h900, 32'h904);
        chk_state("resume", 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
